uart_rx: RTL

Receive half of the PC link: a UART receiver that deserialises bytes from the PC on `rx` and presents them to on-chip logic through a one-entry valid/ack holding register. It is the counterpart to the existing `uart_tx` and shares its parameter set, so the two can sit side by side on `clk_50M`. A later command decoder uses it to accept NOWA, calibration and start-capture commands without using board switches. Framing errors and overruns are reported, not hidden.

---
 rtl/uart_rx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised input, mid-bit sampling, one-entry valid/ack
// holding register with frame-error pulse and sticky overrun flag.
module uart_rx #(
  parameter int unsigned BAUDRATE = 115200,
  parameter int unsigned FREQ     = 50_000_000,
  parameter int unsigned N_start  = 1,
  parameter int unsigned N_data   = 8,
  parameter int unsigned N_stop   = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              rx,
  output logic [N_data-1:0] rdata,
  output logic              rvalid,
  input  logic              rack,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned BIT_PERIOD = FREQ / BAUDRATE;
  localparam int unsigned HALF       = BIT_PERIOD / 2;
  localparam int unsigned CNT_W      = $clog2(BIT_PERIOD);
  localparam int unsigned BIT_W      = 4;

  if (N_start != 1) begin : g_bad_start
    $error("uart_rx: only one start bit is supported");
  end
  if (N_data < 5 || N_data > 9) begin : g_bad_data
    $error("uart_rx: N_data must be 5..9");
  end
  if (N_stop < 1 || N_stop > 2) begin : g_bad_stop
    $error("uart_rx: N_stop must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t             state;
  logic               rx_m;
  logic               rx_s;
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic               stop_idx;
  logic [N_data-1:0]  shreg;
  logic               half_c;
  logic               bit_end_c;
  logic               commit_c;

  assign half_c    = cnt == CNT_W'(HALF - 1);
  assign bit_end_c = cnt == CNT_W'(BIT_PERIOD - 1);
  // Final stop bit sampled high: frame is good and the byte is handed over.
  assign commit_c  = (state == STOP) && bit_end_c && rx_s &&
                     (32'(stop_idx) == N_stop - 1);

  // Input synchroniser, preset to the idle line level.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM; busy is registered alongside state so it mirrors state != IDLE.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      cnt       <= cnt + CNT_W'(1);
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (half_c) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end
        DATA: begin
          if (bit_end_c) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[N_data-1:1]};
            if (bit_idx == BIT_W'(N_data - 1)) begin
              state    <= STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end
        end
        STOP: begin
          if (bit_end_c) begin
            cnt <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else if (commit_c) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: a commit always wins; an ack in the same cycle just
  // means the older byte was consumed, so no overrun is raised.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rdata   <= '0;
      rvalid  <= 1'b0;
      overrun <= 1'b0;
    end else if (commit_c) begin
      rdata   <= shreg;
      rvalid  <= 1'b1;
      overrun <= rvalid & ~rack;
    end else if (rack && rvalid) begin
      rvalid  <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule
